// File: rtl/shift_pkg.sv
// shift_pkg: shared types and helpers for the shift_pipe datapath.
//   shift_mode_e : operation select (SHL, SHR, SAR, ROL)
//   l_of()       : accept-to-output latency for a given multiplier depth
package shift_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    SAR = 2'b10,
    ROL = 2'b11
  } shift_mode_e;

  // One decode stage + multiplier stages + one output stage.
  function automatic int unsigned l_of(input int unsigned mul_stages);
    return mul_stages + 32'd2;
  endfunction

endpackage

// File: rtl/shift_pipe_mul.sv
// mul_pipe: unsigned multiplier followed by STAGES pipeline registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : stage enable; all registers hold while low
//   a, b       : unsigned operands (AW and BW bits)
//   p          : product, AW+BW bits, valid STAGES enabled cycles later
module mul_pipe #(
  parameter int unsigned AW     = 16,
  parameter int unsigned BW     = 17,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic [AW+BW-1:0] p
);

  localparam int unsigned PW = AW + BW;

  logic [PW-1:0] prod_d;
  logic [PW-1:0] pipe_q [STAGES];

  assign prod_d = PW'(a) * PW'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) pipe_q[i] <= '0;
    end else if (en) begin
      pipe_q[0] <= prod_d;
      for (int unsigned i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign p = pipe_q[STAGES-1];

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined shift unit; every shift is a multiply by a decoded
// power of two, with a global-stall valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready = !out_valid || out_ready)
//   in_data, in_dist    : operand and shift distance (0..WIDTH-1)
//   in_mode             : shift_mode_e
//   out_valid/out_ready : output handshake
//   out_data            : 2*WIDTH-bit result
//   out_ovf             : nonzero bits lost or moved above WIDTH
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned DW         = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [DW-1:0]      in_dist,
  input  shift_mode_e        in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_ovf
);

  localparam int unsigned BW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH + 1;

  logic advance;

  // Decode stage
  logic [DW:0]        rdist_d;
  logic [BW-1:0]      b_d;
  logic [WIDTH-1:0]   mask_d;

  logic               vld_dq;
  logic [WIDTH-1:0]   a_q;
  logic [BW-1:0]      b_q;
  shift_mode_e        mode_dq;
  logic               sign_dq;
  logic [WIDTH-1:0]   mask_dq;

  // Sideband travelling alongside the multiplier
  logic               sb_vld_q  [MUL_STAGES];
  shift_mode_e        sb_mode_q [MUL_STAGES];
  logic               sb_sign_q [MUL_STAGES];
  logic [WIDTH-1:0]   sb_mask_q [MUL_STAGES];

  // Multiplier result and output stage
  logic [PW-1:0]      p;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic               unused_p_top;
  logic [2*WIDTH-1:0] data_d;
  logic               ovf_d;

  logic               out_valid_q;
  logic [2*WIDTH-1:0] out_data_q;
  logic               out_ovf_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Right shifts become a left multiply by 2^(WIDTH-d) whose upper half is
  // the shifted value; d=0 therefore needs the full WIDTH+1-bit operand.
  assign rdist_d = (DW+1)'(WIDTH) - {1'b0, in_dist};
  assign mask_d  = ~({WIDTH{1'b1}} >> in_dist);

  always_comb begin
    b_d = '0;
    case (in_mode)
      SHL, ROL: b_d = BW'(1) << in_dist;
      default:  b_d = BW'(1) << rdist_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_dq  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode_dq <= SHL;
      sign_dq <= 1'b0;
      mask_dq <= '0;
    end else if (advance) begin
      vld_dq  <= in_valid;
      a_q     <= in_data;
      b_q     <= b_d;
      mode_dq <= in_mode;
      sign_dq <= in_data[WIDTH-1];
      mask_dq <= mask_d;
    end
  end

  mul_pipe #(
    .AW    (WIDTH),
    .BW    (BW),
    .STAGES(MUL_STAGES)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (advance),
    .a    (a_q),
    .b    (b_q),
    .p    (p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        sb_vld_q[i]  <= 1'b0;
        sb_mode_q[i] <= SHL;
        sb_sign_q[i] <= 1'b0;
        sb_mask_q[i] <= '0;
      end
    end else if (advance) begin
      sb_vld_q[0]  <= vld_dq;
      sb_mode_q[0] <= mode_dq;
      sb_sign_q[0] <= sign_dq;
      sb_mask_q[0] <= mask_dq;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        sb_vld_q[i]  <= sb_vld_q[i-1];
        sb_mode_q[i] <= sb_mode_q[i-1];
        sb_sign_q[i] <= sb_sign_q[i-1];
        sb_mask_q[i] <= sb_mask_q[i-1];
      end
    end
  end

  // a < 2^W and b <= 2^W, so the product never reaches bit 2W.
  assign p_hi         = p[2*WIDTH-1:WIDTH];
  assign p_lo         = p[WIDTH-1:0];
  assign unused_p_top = p[2*WIDTH];

  always_comb begin
    data_d = '0;
    ovf_d  = 1'b0;
    case (sb_mode_q[MUL_STAGES-1])
      SHL: begin
        data_d = p[2*WIDTH-1:0];
        ovf_d  = |p_hi;
      end
      SHR: begin
        data_d = {{WIDTH{1'b0}}, p_hi};
        ovf_d  = |p_lo;
      end
      SAR: begin
        data_d = {{WIDTH{sb_sign_q[MUL_STAGES-1]}},
                  p_hi | (sb_sign_q[MUL_STAGES-1] ? sb_mask_q[MUL_STAGES-1] : '0)};
        ovf_d  = |p_lo;
      end
      ROL: begin
        data_d = {{WIDTH{1'b0}}, p_lo | p_hi};
        ovf_d  = 1'b0;
      end
      default: begin
        data_d = '0;
        ovf_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= sb_vld_q[MUL_STAGES-1];
      out_data_q  <= data_d;
      out_ovf_q   <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;
  import shift_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned S   = 2;
  localparam int unsigned DWB = $clog2(W);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic [DWB-1:0]   in_dist = '0;
  shift_mode_e      in_mode = SHL;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [2*W-1:0]   out_data;
  logic             out_ovf;

  shift_pipe #(.WIDTH(W), .MUL_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dist  (in_dist),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_recv = 0;
  int n_stall = 0;
  int cyc = 0;
  int unsigned lat_exp;
  bit chk_lat = 1'b0;
  logic [2*W-1:0] last_d = '0;
  logic           last_o = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: shifts expressed directly as arithmetic on the operand.
  function automatic void model(input logic [W-1:0] a, input int d, input shift_mode_e m,
                                output logic [2*W-1:0] r, output logic o);
    logic [2*W-1:0] ax;
    logic [2*W-1:0] lost_mask;
    ax        = {{W{1'b0}}, a};
    lost_mask = (2*W)'((64'd1 << d) - 64'd1);
    o = 1'b0;
    r = '0;
    case (m)
      SHL: begin r = ax << d; o = ((r >> W) != 0); end
      SHR: begin r = ax >> d; o = ((ax & lost_mask) != 0); end
      SAR: begin
        r = $unsigned($signed({{W{a[W-1]}}, a}) >>> d);
        o = ((ax & lost_mask) != 0);
      end
      default: r = (d == 0) ? ax : (((ax << d) | (ax >> (W - d))) & {{W{1'b0}}, {W{1'b1}}});
    endcase
  endfunction

  typedef struct {
    logic [2*W-1:0] d;
    logic           o;
    int             acc;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) begin
      exp_t e;
      model(in_data, int'(in_dist), in_mode, e.d, e.o);
      e.acc = cyc;
      q.push_back(e);
    end
  end

  logic           stall_p = 1'b0;
  logic [2*W-1:0] st_d;
  logic           st_o;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, st_d);
        check("stall_ovf", out_ovf, st_o);
      end
      if (out_valid && !out_ready) begin
        n_stall++;
        check("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        n_recv++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_output: got data %0h with nothing outstanding (t=%0t)", out_data, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("data", out_data, e.d);
          check("ovf", out_ovf, e.o);
          if (chk_lat) check("latency", 64'(cyc - e.acc), 64'(lat_exp));
          last_d = out_data;
          last_o = out_ovf;
        end
      end
      stall_p = out_valid && !out_ready;
      st_d    = out_data;
      st_o    = out_ovf;
    end
  end

  // out_ready pattern: 0 always ready, 1 backpressure window, 2 random
  int rmode = 0;
  int bp_start = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      1:       out_ready = !(((cyc - bp_start) >= 5) && ((cyc - bp_start) <= 9));
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // Called at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input int d, input shift_mode_e m);
    int g = 0;
    in_valid = 1'b1;
    in_data  = a;
    in_dist  = DWB'(d);
    in_mode  = m;
    while (!in_ready && g < 100) begin
      @(negedge clk); #1;
      g++;
    end
    if (g >= 100) check("send_timeout", in_ready, 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_drain(input int max);
    int g = 0;
    while (q.size() != 0 && g < max) begin
      @(negedge clk); #1;
      g++;
    end
    check("drain", q.size(), 0);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    int             d;
    shift_mode_e    m;
    logic [2*W-1:0] ed;
    logic           eo;
  } vec_t;
  vec_t tab[11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0;
    lat_exp = l_of(S);
    tab[0]  = '{16'h8001, 15, SHL, 32'h40008000, 1'b1};
    tab[1]  = '{16'h0003,  0, SHL, 32'h00000003, 1'b0};
    tab[2]  = '{16'h8001,  1, SHR, 32'h00004000, 1'b1};
    tab[3]  = '{16'h8001,  0, SHR, 32'h00008001, 1'b0};
    tab[4]  = '{16'h8000,  3, SAR, 32'hFFFFF000, 1'b0};
    tab[5]  = '{16'h4001,  1, SAR, 32'h00002000, 1'b1};
    tab[6]  = '{16'h8001,  4, ROL, 32'h00000018, 1'b0};
    tab[7]  = '{16'hFFFF, 15, ROL, 32'h0000FFFF, 1'b0};
    tab[8]  = '{16'h8000,  0, SAR, 32'hFFFF8000, 1'b0};
    tab[9]  = '{16'hFFFF, 15, SHL, 32'h7FFF8000, 1'b1};
    tab[10] = '{16'h1234,  0, ROL, 32'h00001234, 1'b0};

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors, one at a time, latency checked
    chk_lat = 1'b1;
    foreach (tab[i]) begin
      send(tab[i].a, tab[i].d, tab[i].m);
      in_valid = 1'b0;
      wait_drain(20);
      check($sformatf("tab%0d_data", i), last_d, tab[i].ed);
      check($sformatf("tab%0d_ovf", i), last_o, tab[i].eo);
    end

    // Backpressure: 8 back-to-back ops, out_ready low for 5 cycles
    chk_lat  = 1'b0;
    r0       = n_recv;
    s0       = n_stall;
    bp_start = cyc;
    rmode    = 1;
    for (int i = 0; i < 8; i++)
      send(W'($urandom), int'($urandom_range(0, W-1)), shift_mode_e'($urandom_range(0, 3)));
    in_valid = 1'b0;
    wait_drain(100);
    check("bp_count", n_recv - r0, 8);
    check("bp_stall_cycles", n_stall - s0, 5);
    rmode = 0;
    @(negedge clk); #1;

    // Random traffic with random backpressure and input gaps
    rmode = 2;
    r0    = n_recv;
    for (int i = 0; i < 150; i++) begin
      send(W'($urandom), int'($urandom_range(0, W-1)), shift_mode_e'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk); #1;
      end
    end
    in_valid = 1'b0;
    wait_drain(400);
    check("rand_count", n_recv - r0, 150);
    rmode = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;

    // Reset with three operations in flight
    send(16'h00F0, 2, SHL);
    send(16'h8F00, 5, SAR);
    send(16'h0F0F, 7, ROL);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    q.delete();
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    r0 = n_recv;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
    end
    check("post_rst_silent", n_recv - r0, 0);
    chk_lat = 1'b1;
    send(16'h0ABC, 3, SHR);
    in_valid = 1'b0;
    wait_drain(20);
    check("post_rst_count", n_recv - r0, 1);
    check("post_rst_data", last_d, 32'h00000157);
    check("post_rst_ovf", last_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, fully pipelined shift unit that implements shifts as multiplication by a decoded power of two. It generalises the fixed 16-bit shift-by-multiply block to any power-of-two `WIDTH` and a configurable multiplier depth, and adds four shift modes, overflow reporting and a valid/ready handshake with backpressure. It sits in the datapath beside the other arithmetic units. It accepts one operation per cycle when not stalled.

## Interface

Parameters:

- `WIDTH`, default 16: operand width; power of two, 4..64.
- `MUL_STAGES`, default 2: register stages inside the multiplier; 1..4.
- `DW`, default `$clog2(WIDTH)`: distance width; derived, do not override.

Ports:

- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input operation present.
- `in_ready`  out  1  unit accepts this cycle.
- `in_data`  in  `WIDTH`  operand.
- `in_dist`  in  `DW`  shift distance, 0..`WIDTH`-1.
- `in_mode`  in  2  `shift_mode_e`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  `2*WIDTH`  result.
- `out_ovf`  out  1  nonzero bits lost or moved above `WIDTH`.

## Operation

- Accept happens when `in_valid && in_ready`. Transfer out happens when `out_valid && out_ready`.
- Stage D (decode, registered):
  - Multiplier operand `b` is `WIDTH+1` bits.
  - SHL and ROL use `b = 1<<d`.
  - SHR and SAR use `b = 1<<(WIDTH-d)`, so `d=0` gives `b = 2^WIDTH`.
  - Also registered in this stage: mode, sign bit `in_data[WIDTH-1]`, and fill mask `~({WIDTH{1}} >> d)`.
- Stage M: `mul_pipe` forms the unsigned product `P = a*b` (`2*WIDTH+1` bits) over `MUL_STAGES` cycles. Mode, sign and mask travel in a matching sideband shift register.
- Stage O (output, registered), per mode:
  - SHL: `out_data = P[2W-1:0]`; `out_ovf = |P[2W-1:W]`.
  - SHR: `out_data = {W'0, P[2W-1:W]}`; `out_ovf = |P[W-1:0]`.
  - SAR: lower half `= P[2W-1:W] | (sign ? mask : 0)`; upper half `= {W{sign}}`; `out_ovf = |P[W-1:0]`.
  - ROL: `out_data = {W'0, P[W-1:0] | P[2W-1:W]}`; `out_ovf = 0`.
  - `d=0` in any mode: `out_data` is `in_data`, zero- or sign-extended as the mode requires; `out_ovf = 0`.
- Global stall:
  - `advance = !out_valid || out_ready`.
  - `in_ready = advance`. It depends combinationally on `out_ready`; no skid buffer.
  - All stages and valid bits move only when `advance` is high. Bubbles carry `valid=0`.
- Ordering: strictly in order. No drops, no duplicates.
- Bits of `in_dist` outside the range are impossible by width; no check is needed.

## Timing

- Latency: `L = MUL_STAGES + 2` cycles from accept to `out_valid`, with no stall. Default `L = 4`.
- Throughput: one operation per cycle while `out_ready` stays high.
- Stall: while `out_valid && !out_ready`:
  - `out_data`, `out_ovf` and `out_valid` hold stable.
  - `in_ready` is low.
  - Every internal stage holds.
- Reset (`rst_n` low, asynchronous):
  - All valid bits go to 0, along with `out_valid`, `out_data`, `out_ovf` and the sideband registers.
  - `in_ready` becomes 1 immediately (`out_valid = 0`).
  - In-flight operations are discarded; none emerge after release.
- First accept is possible in the first cycle after `rst_n` deasserts.
- Same-cycle output transfer and new accept is allowed.

## Structure

- Package `shift_pkg`:
  - `typedef enum logic [1:0] shift_mode_e {SHL=2'b00, SHR=2'b01, SAR=2'b10, ROL=2'b11}`.
  - Function `l_of(mul_stages)` returning the latency, for benches.
- Sub-module `mul_pipe`:
  - Parameters `AW`, `BW`, `STAGES`.
  - Ports `clk`, `rst_n`, `en`, `a`, `b`, `p`.
  - Unsigned product, `STAGES` registers, stalled by `en`.
- Top level holds: decode stage, sideband shift register, output mux/registers, valid chain.

## Test plan

Defaults: `WIDTH=16`, `MUL_STAGES=2`, `L=4`, `out_ready=1` unless stated.

- SHL `0x8001` by 15 → `out_data = 0x40008000`, `out_ovf = 1`, 4 cycles after accept. SHL `0x0003` by 0 → `0x00000003`, `ovf = 0`.
- SHR `0x8001` by 1 → `0x00004000`, `ovf = 1`. SHR `0x8001` by 0 → `0x00008001`, `ovf = 0`.
- SAR `0x8000` by 3 → `0xFFFFF000`, `ovf = 0`. SAR `0x4001` by 1 → `0x00002000`, `ovf = 1`.
- ROL `0x8001` by 4 → `0x00000018`, `ovf = 0`. ROL `0xFFFF` by 15 → `0x0000FFFF`.
- Backpressure: stream 8 random operations back-to-back with `out_ready` low for cycles 5–9. Required: `in_ready` low during the stall, outputs stable, all 8 results in order and matching the reference model, no loss or duplication.
- Reset: 3 operations in flight, pull `rst_n` low mid-cycle. Required: `out_valid` 0 immediately; after release there is no output until a new accept, and that result arrives at exactly `L`.
